// File: rtl/systolic_pkg.sv
// Shared types and arithmetic helpers for the output-stationary GEMM tile engine.
package systolic_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DRAIN} state_e;

    // Working width of the saturating adder; accumulators up to 63 bits fit without overflow.
    localparam int SAT_W = 64;

    function automatic int cnt_w(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    function automatic int row_w(input int n_rows);
        return (n_rows > 1) ? $clog2(n_rows) : 1;
    endfunction

    // acc and prod arrive already sign/zero extended to SAT_W from a w-bit accumulator.
    // Returns {sat, clamped_sum}; the clamped sum always fits back into w bits.
    function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] prod,
                                               input int unsigned      w,
                                               input logic             is_signed);
        logic signed [SAT_W-1:0] s_sum, s_max, s_min;
        logic        [SAT_W-1:0] u_sum, u_max, lim, res;
        logic                    sat;
        lim   = SAT_W'(1) << (w - 1);
        s_max = $signed(lim - SAT_W'(1));
        s_min = -$signed(lim);
        u_max = (SAT_W'(1) << w) - SAT_W'(1);
        s_sum = $signed(acc) + $signed(prod);
        u_sum = acc + prod;
        sat   = 1'b0;
        if (is_signed) begin
            res = s_sum;
            if (s_sum > s_max) begin
                res = s_max;
                sat = 1'b1;
            end else if (s_sum < s_min) begin
                res = s_min;
                sat = 1'b1;
            end
        end else begin
            res = u_sum;
            if (u_sum > u_max) begin
                res = u_max;
                sat = 1'b1;
            end
        end
        return {sat, res};
    endfunction

endpackage

// File: rtl/systolic_os_tile_engine_pe.sv
// One output-stationary PE: forwards A right and B down, accumulates A*B with saturation.
module os_pe
    import systolic_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             clear,
    input  logic             is_signed,
    input  logic [A_W-1:0]   a_in,
    input  logic             a_vin,
    input  logic [B_W-1:0]   b_in,
    input  logic             b_vin,
    output logic [A_W-1:0]   a_out,
    output logic             a_vout,
    output logic [B_W-1:0]   b_out,
    output logic             b_vout,
    output logic [ACC_W-1:0] acc,
    output logic             sat
);
    localparam int P_W = A_W + B_W;

    logic [P_W-1:0]   prod;
    logic [SAT_W-1:0] prod_x, acc_x;
    logic [ACC_W-1:0] sum_c;
    logic             hit_c, fire;

    // Product and saturating sum; the two sat_add calls are identical and share logic.
    always_comb begin
        if (is_signed) begin
            prod   = $signed({{B_W{a_in[A_W-1]}}, a_in}) * $signed({{A_W{b_in[B_W-1]}}, b_in});
            prod_x = {{(SAT_W-P_W){prod[P_W-1]}}, prod};
            acc_x  = {{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc};
        end else begin
            prod   = {{B_W{1'b0}}, a_in} * {{A_W{1'b0}}, b_in};
            prod_x = {{(SAT_W-P_W){1'b0}}, prod};
            acc_x  = {{(SAT_W-ACC_W){1'b0}}, acc};
        end
        fire  = advance & a_vin & b_vin;
        sum_c = ACC_W'(sat_add(acc_x, prod_x, ACC_W, is_signed));
        hit_c = 1'(sat_add(acc_x, prod_x, ACC_W, is_signed) >> SAT_W);
        sat   = fire & hit_c;
    end

    // Operand pass-through registers and the stationary accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out  <= '0;
            a_vout <= 1'b0;
            b_out  <= '0;
            b_vout <= 1'b0;
            acc    <= '0;
        end else begin
            if (advance) begin
                a_out  <= a_in;
                a_vout <= a_vin;
                b_out  <= b_in;
                b_vout <= b_vin;
            end
            if (clear) begin
                acc <= '0;
            end else if (fire) begin
                acc <= sum_c;
            end
        end
    end

endmodule

// File: rtl/systolic_os_tile_engine.sv
// Output-stationary GEMM tile engine: skews A/B beats into a PE grid and drains C row by row.
//
// state  | meaning
// IDLE   | waiting for start; cfg latched on start
// CLEAR  | one cycle zeroing every accumulator
// STREAM | accepting operand beats; array advances per handshake
// FLUSH  | pushing invalid bubbles until the last product lands
// DRAIN  | presenting C rows 0..N_ROWS-1 on the output stream
module systolic_os_tile_engine
    import systolic_pkg::*;
#(
    parameter int N_ROWS = 8,
    parameter int N_COLS = 8,
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [cnt_w(K_MAX)-1:0]   cfg_k,
    input  logic                      cfg_signed,
    input  logic                      cfg_accum,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_ROWS*A_W-1:0]     a_data,
    input  logic [N_COLS*B_W-1:0]     b_data,
    output logic                      c_valid,
    input  logic                      c_ready,
    output logic [N_COLS*ACC_W-1:0]   c_data,
    output logic [row_w(N_ROWS)-1:0]  c_row,
    output logic                      c_last,
    output logic                      sat_flag
);
    localparam int CNT_W = cnt_w(K_MAX);
    localparam int ROW_W = row_w(N_ROWS);
    localparam int FL_W  = $clog2(N_ROWS + N_COLS);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(N_ROWS + N_COLS - 2);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N_ROWS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_cnt;
    logic [FL_W-1:0]  fl_cnt;
    logic             signed_q, clear_acc, advance, push_v, sat_any;

    logic [A_W-1:0]   a_bus  [N_ROWS][N_COLS+1];
    logic             av_bus [N_ROWS][N_COLS+1];
    logic [B_W-1:0]   b_bus  [N_ROWS+1][N_COLS];
    logic             bv_bus [N_ROWS+1][N_COLS];
    logic [ACC_W-1:0] acc_q  [N_ROWS][N_COLS];
    logic             sat_bus[N_ROWS][N_COLS];

    // In STREAM the array steps only on a handshake; in FLUSH it steps every cycle with bubbles.
    assign advance = ((state_q == STREAM) && in_valid) || (state_q == FLUSH);
    assign push_v  = (state_q == STREAM);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        c_valid   = 1'b0;
        clear_acc = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!cfg_accum)         state_d = CLEAR;
                    else if (cfg_k == '0)   state_d = DRAIN;
                    else                    state_d = STREAM;
                end
            end
            CLEAR: begin
                clear_acc = 1'b1;
                state_d   = (k_q == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                in_ready = 1'b1;
                if (in_valid && (k_cnt + CNT_W'(1) == k_q)) state_d = FLUSH;
            end
            FLUSH: begin
                if (fl_cnt == FLUSH_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                c_valid = 1'b1;
                if (c_ready && (c_row == ROW_LAST)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration latch, beat/flush/row counters, done pulse and sticky saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= '0;
            signed_q <= 1'b0;
            k_cnt    <= '0;
            fl_cnt   <= '0;
            c_row    <= '0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            done   <= (state_q == DRAIN) && c_ready && (c_row == ROW_LAST);
            fl_cnt <= (state_q == FLUSH) ? fl_cnt + FL_W'(1) : '0;
            if (state_q == IDLE && start) begin
                k_q      <= cfg_k;
                signed_q <= cfg_signed;
                k_cnt    <= '0;
                sat_flag <= 1'b0;
            end else begin
                if (sat_any) sat_flag <= 1'b1;
                if (state_q == STREAM && in_valid) k_cnt <= k_cnt + CNT_W'(1);
            end
            if (state_q == DRAIN && c_ready) begin
                c_row <= (c_row == ROW_LAST) ? '0 : c_row + ROW_W'(1);
            end
        end
    end

    assign c_last = c_valid && (c_row == ROW_LAST);

    // Row mux for the output stream and OR of per-PE saturation pulses.
    always_comb begin
        c_data  = '0;
        sat_any = 1'b0;
        for (int c = 0; c < N_COLS; c++) begin
            c_data[c*ACC_W +: ACC_W] = acc_q[c_row][c];
        end
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                sat_any = sat_any | sat_bus[r][c];
            end
        end
    end

    for (genvar r = 0; r < N_ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_bus[0][0]  = a_data[A_W-1:0];
            assign av_bus[0][0] = push_v;
        end else begin : g_delay
            logic [A_W-1:0] d_q [r];
            logic           v_q [r];
            // Row r of A is delayed r advance steps.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) begin
                        d_q[i] <= '0;
                        v_q[i] <= 1'b0;
                    end
                end else if (advance) begin
                    d_q[0] <= a_data[r*A_W +: A_W];
                    v_q[0] <= push_v;
                    for (int i = 1; i < r; i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end
            assign a_bus[r][0]  = d_q[r-1];
            assign av_bus[r][0] = v_q[r-1];
        end
    end

    for (genvar c = 0; c < N_COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_bus[0][0]  = b_data[B_W-1:0];
            assign bv_bus[0][0] = push_v;
        end else begin : g_delay
            logic [B_W-1:0] d_q [c];
            logic           v_q [c];
            // Column c of B is delayed c advance steps.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c; i++) begin
                        d_q[i] <= '0;
                        v_q[i] <= 1'b0;
                    end
                end else if (advance) begin
                    d_q[0] <= b_data[c*B_W +: B_W];
                    v_q[0] <= push_v;
                    for (int i = 1; i < c; i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end
            assign b_bus[0][c]  = d_q[c-1];
            assign bv_bus[0][c] = v_q[c-1];
        end
    end

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        for (genvar c = 0; c < N_COLS; c++) begin : g_col
            os_pe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) u_pe (
                .clk      (clk),
                .rst      (rst),
                .advance  (advance),
                .clear    (clear_acc),
                .is_signed(signed_q),
                .a_in     (a_bus[r][c]),
                .a_vin    (av_bus[r][c]),
                .b_in     (b_bus[r][c]),
                .b_vin    (bv_bus[r][c]),
                .a_out    (a_bus[r][c+1]),
                .a_vout   (av_bus[r][c+1]),
                .b_out    (b_bus[r+1][c]),
                .b_vout   (bv_bus[r+1][c]),
                .acc      (acc_q[r][c]),
                .sat      (sat_bus[r][c])
            );
        end
    end

endmodule

// File: tb/tb_systolic_os_tile_engine.sv
// Scoreboard bench for the tile engine: a plain-arithmetic GEMM model fills an expected-row queue.
module tb_systolic_os_tile_engine;
    localparam int NR = 4, NC = 4, AW = 8, BW = 8, ACCW = 16, KM = 64, CW = 7, RW = 2;

    logic                clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [CW-1:0]       cfg_k = '0;
    logic                cfg_signed = 1'b0, cfg_accum = 1'b0;
    logic                busy, done, in_ready, c_valid, c_last, sat_flag;
    logic                in_valid = 1'b0, c_ready = 1'b1;
    logic [NR*AW-1:0]    a_data = '0;
    logic [NC*BW-1:0]    b_data = '0;
    logic [NC*ACCW-1:0]  c_data;
    logic [RW-1:0]       c_row;

    systolic_os_tile_engine #(.N_ROWS(NR), .N_COLS(NC), .A_W(AW), .B_W(BW), .ACC_W(ACCW), .K_MAX(KM)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_signed(cfg_signed),
        .cfg_accum(cfg_accum), .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .b_data(b_data), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .c_row(c_row), .c_last(c_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          row;
        bit          last;
        bit          sat;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           n_checks = 0, n_fail = 0, hs_cnt = 0, stall_left = 0;
    bit           rand_ready = 0, done_due = 0, hold_v = 0;
    logic [63:0]  hold_data;
    logic [RW-1:0] hold_row;
    logic [7:0]   op_a [KM][NR];
    logic [7:0]   op_b [KM][NC];
    logic [15:0]  mdl  [NR][NC];

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic longint val16(logic [15:0] v, bit s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic longint val8(logic [7:0] v, bit s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    // Reference: C[r][c] += A[r][k]*B[k][c] for each k in order, clamped to the ACC_W range each step.
    task automatic model_tile(int first, int k, bit s, bit accum);
        bit     any_sat = 0;
        longint v, lo, hi;
        exp_t   e;
        lo = s ? -32768 : 0;
        hi = s ? 32767 : 65535;
        if (!accum) foreach (mdl[r, c]) mdl[r][c] = '0;
        for (int kk = first; kk < first + k; kk++) begin
            for (int r = 0; r < NR; r++) begin
                for (int c = 0; c < NC; c++) begin
                    v = val16(mdl[r][c], s) + val8(op_a[kk][r], s) * val8(op_b[kk][c], s);
                    if (v > hi) begin v = hi; any_sat = 1; end
                    if (v < lo) begin v = lo; any_sat = 1; end
                    mdl[r][c] = 16'(v);
                end
            end
        end
        for (int r = 0; r < NR; r++) begin
            e.data = '0;
            for (int c = 0; c < NC; c++) e.data[c*16 +: 16] = mdl[r][c];
            e.row  = r;
            e.last = (r == NR - 1);
            e.sat  = any_sat;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_tile(int k, bit s, bit accum);
        start = 1'b1; cfg_k = CW'(k); cfg_signed = s; cfg_accum = accum;
        @(posedge clk); #1;
        start = 1'b0; cfg_k = CW'($urandom); cfg_signed = 1'($urandom); cfg_accum = 1'($urandom);
    endtask

    // Offer beats first..first+n-1; with gap set in_valid toggles and start is randomly raised while busy.
    task automatic send_beats(int first, int n, bit gap);
        int kk = first;
        int guard = 0;
        bit tog = 1;
        while (kk < first + n) begin
            in_valid = gap ? tog : 1'b1;
            tog = ~tog;
            for (int r = 0; r < NR; r++) a_data[r*8 +: 8] = in_valid ? op_a[kk][r] : 8'($urandom);
            for (int c = 0; c < NC; c++) b_data[c*8 +: 8] = in_valid ? op_b[kk][c] : 8'($urandom);
            start = gap ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) kk++;
            @(posedge clk); #1;
            guard++;
            if (guard > 2000) begin
                n_checks++; n_fail++;
                $display("FAIL beat_timeout actual=%0d required=%0d", kk - first, n);
                break;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    // Keep offering junk beats until the tile returns to IDLE; none of them may be accepted.
    task automatic wait_idle();
        int guard = 0;
        in_valid = 1'b1;
        forever begin
            a_data = 32'($urandom); b_data = 32'($urandom);
            @(negedge clk);
            if (!busy) break;
            @(posedge clk); #1;
            guard++;
            if (guard > 1000) begin
                n_checks++; n_fail++;
                $display("FAIL tile_timeout actual=busy required=idle");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_tile(int first, int k, bit s, bit accum, bit gap);
        int snap = hs_cnt;
        model_tile(first, k, s, accum);
        start_tile(k, s, accum);
        send_beats(first, k, gap);
        wait_idle();
        check("beats_accepted", 64'(hs_cnt - snap), 64'(k));
    endtask

    task automatic load_identity();
        for (int kk = 0; kk < 4; kk++) begin
            for (int r = 0; r < NR; r++) op_a[kk][r] = (r == kk) ? 8'd1 : 8'd0;
            for (int c = 0; c < NC; c++) op_b[kk][c] = 8'(10 * kk + c);
        end
    endtask

    // Output-side ready driver: optional 3-cycle stall on row 1, otherwise always or randomly ready.
    initial forever begin
        @(posedge clk); #1;
        if (stall_left > 0 && c_valid && c_row == RW'(1)) begin
            c_ready = 1'b0;
            stall_left--;
        end else begin
            c_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each accepted C row and checks done/stall behaviour.
    initial forever begin
        @(negedge clk);
        if (in_valid && in_ready) hs_cnt++;
        if (done_due) begin
            check("done_pulse", 64'(done), 64'd1);
            done_due = 0;
        end else if (done) begin
            n_checks++; n_fail++;
            $display("FAIL done_spurious actual=1 required=0");
        end
        if (c_valid) begin
            if (hold_v) begin
                check("stall_data", c_data, hold_data);
                check("stall_row", 64'(c_row), 64'(hold_row));
            end
            if (c_ready) begin
                hold_v = 0;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_row actual=%0d required=none", c_row);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("c_data", c_data, mon_e.data);
                    check("c_row", 64'(c_row), 64'(mon_e.row));
                    check("c_last", 64'(c_last), 64'(mon_e.last));
                    if (mon_e.last) begin
                        check("sat_flag", 64'(sat_flag), 64'(mon_e.sat));
                        done_due = 1;
                    end
                end
            end else begin
                hold_v = 1;
                hold_data = c_data;
                hold_row = c_row;
            end
        end else begin
            hold_v = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (mdl[r, c]) mdl[r][c] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_c_valid", 64'(c_valid), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_c_data", c_data, 64'd0);
        check("rst_c_row", 64'(c_row), 64'd0);
        check("rst_c_last", 64'(c_last), 64'd0);
        @(posedge clk); #1;

        // Identity A against B[k,c]=10k+c, then the same with input gaps and an output stall.
        load_identity();
        run_tile(0, 4, 1, 0, 0);
        stall_left = 3;
        run_tile(0, 4, 1, 0, 1);
        check("stall_consumed", 64'(stall_left), 64'd0);

        // Saturation: signed 127*127*3 and unsigned 255*255*2, then a large negative without clamp.
        for (int kk = 0; kk < 3; kk++) foreach (op_a[0][r]) begin op_a[kk][r] = 8'd127; op_b[kk][r] = 8'd127; end
        run_tile(0, 3, 1, 0, 0);
        for (int kk = 0; kk < 2; kk++) foreach (op_a[0][r]) begin op_a[kk][r] = 8'd255; op_b[kk][r] = 8'd255; end
        run_tile(0, 2, 0, 0, 0);
        for (int kk = 0; kk < 2; kk++) foreach (op_a[0][r]) begin op_a[kk][r] = 8'h80; op_b[kk][r] = 8'd127; end
        run_tile(0, 2, 1, 0, 0);

        // Cross-tile accumulation: 2 + 2 beats equal one K=4 tile; K=0 re-drains the held values.
        for (int kk = 0; kk < 4; kk++) foreach (op_a[0][r]) begin op_a[kk][r] = 8'($urandom); op_b[kk][r] = 8'($urandom); end
        run_tile(0, 2, 1, 0, 0);
        run_tile(2, 2, 1, 1, 0);
        run_tile(0, 0, 1, 1, 0);
        run_tile(0, 0, 1, 0, 0);

        // Reset two beats into a tile, then an accumulate tile proves the accumulators were zeroed.
        load_identity();
        start_tile(4, 1, 0);
        send_beats(0, 2, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        foreach (mdl[r, c]) mdl[r][c] = '0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_c_valid", 64'(c_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        run_tile(0, 4, 1, 1, 0);

        // Random tiles with random modes, input gaps and random output backpressure.
        rand_ready = 1;
        for (int t = 0; t < 10; t++) begin
            int k;
            k = $urandom_range(1, 6);
            for (int kk = 0; kk < k; kk++) foreach (op_a[0][r]) begin op_a[kk][r] = 8'($urandom); op_b[kk][r] = 8'($urandom); end
            run_tile(0, k, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_ready = 0;

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
